uart_cmd_hub: RTL and testbench



---
 rtl/la_cmd_pkg.sv | 36 +++
 rtl/cmd_timeout_ctr.sv | 41 ++++
 rtl/uart_cmd_hub.sv | 178 +++++++++++++++++
 tb/tb_uart_cmd_hub.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_cmd_pkg.sv
// ============================================================================
//  Module      : la_cmd_pkg
//  Description : Shared opcodes, FSM state encodings and default response
//                characters for the logic-analyzer UART command hub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package la_cmd_pkg;

    // Host opcodes (ASCII)
    localparam logic [7:0] OP_WRITE  = 8'h57;  // 'W'
    localparam logic [7:0] OP_READ   = 8'h52;  // 'R'
    localparam logic [7:0] OP_STATUS = 8'h53;  // 'S'

    // Default response characters
    localparam logic [7:0] DEFAULT_ACK = 8'h4B;  // 'K'
    localparam logic [7:0] DEFAULT_NAK = 8'h3F;  // '?'

    // FSM state encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GET_ADDR   = 3'd1;
    localparam logic [2:0] ST_GET_DATA   = 3'd2;
    localparam logic [2:0] ST_BUS_WR     = 3'd3;
    localparam logic [2:0] ST_BUS_RD     = 3'd4;
    localparam logic [2:0] ST_RD_CAPTURE = 3'd5;
    localparam logic [2:0] ST_SEND       = 3'd6;

    // Increment that sticks at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? 8'hFF : value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_timeout_ctr.sv
// ============================================================================
//  Module      : cmd_timeout_ctr
//  Description : Loadable down-counter used to abandon stalled partial frames.
//                load has priority over clear, clear over decrement.
//                expired is high whenever the count is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_timeout_ctr #(
    parameter int               WIDTH      = 20,
    parameter logic [WIDTH-1:0] LOAD_VALUE = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [WIDTH-1:0] count;

    // Count register: reload on each popped byte, count down while starved
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (clear) begin
            count <= '0;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_hub.sv
// ============================================================================
//  Module      : uart_cmd_hub
//  Description : Pops W/R/S command frames from the UART receive FIFO, runs
//                single-cycle register bus transactions and pushes one
//                response byte per frame into the UART transmit FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_hub
    import la_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_CHAR       = DEFAULT_ACK,
    parameter logic [7:0] NAK_CHAR       = DEFAULT_NAK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_present,
    output logic       rx_read,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_full,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] opcode;
    logic [7:0] resp;
    logic [7:0] resp_next;
    logic [7:0] addr_q;
    logic [7:0] wr_data_q;
    logic [7:0] err_q;
    logic       pop_hold;   // forces an idle cycle after every pop
    logic       in_get;
    logic       tmo_expired;
    logic       timeout;
    logic       pop;
    logic       tmo_load;
    logic       err_inc;

    assign in_get  = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign timeout = in_get && tmo_expired;
    // A pop is allowed only in byte-collecting states, never on consecutive
    // cycles, and never in the cycle a partial frame is being abandoned.
    assign pop     = rx_present && !pop_hold && !timeout &&
                     ((state == ST_IDLE) || in_get);

    // Next-state, response and side-effect decode
    always_comb begin
        state_next = state;
        resp_next  = resp;
        tmo_load   = 1'b0;
        err_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        state_next = ST_GET_ADDR;
                        tmo_load   = 1'b1;
                    end else if (rx_data == OP_STATUS) begin
                        state_next = ST_SEND;
                        resp_next  = {err_q[3:0], 3'b000, tx_full};
                    end else begin
                        state_next = ST_SEND;
                        resp_next  = NAK_CHAR;
                        err_inc    = 1'b1;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (timeout) begin
                    state_next = ST_IDLE;
                    err_inc    = 1'b1;
                end else if (pop) begin
                    if (opcode == OP_WRITE) begin
                        state_next = ST_GET_DATA;
                        tmo_load   = 1'b1;
                    end else begin
                        state_next = ST_BUS_RD;
                    end
                end
            end
            ST_GET_DATA: begin
                if (timeout) begin
                    state_next = ST_IDLE;
                    err_inc    = 1'b1;
                end else if (pop) begin
                    state_next = ST_BUS_WR;
                end
            end
            ST_BUS_WR: begin
                resp_next  = ACK_CHAR;
                state_next = ST_SEND;
            end
            ST_BUS_RD: begin
                state_next = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                resp_next  = reg_rd_data;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_full) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, captured frame fields, response and error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            opcode    <= 8'h00;
            resp      <= 8'h00;
            addr_q    <= 8'h00;
            wr_data_q <= 8'h00;
            err_q     <= 8'h00;
            pop_hold  <= 1'b1;
        end else begin
            state    <= state_next;
            resp     <= resp_next;
            pop_hold <= pop;
            if (pop && (state == ST_IDLE)) begin
                opcode <= rx_data;
            end
            if (pop && (state == ST_GET_ADDR)) begin
                addr_q <= rx_data;
            end
            if (pop && (state == ST_GET_DATA)) begin
                wr_data_q <= rx_data;
            end
            if (err_inc) begin
                err_q <= sat_inc8(err_q);
            end
        end
    end

    cmd_timeout_ctr #(
        .WIDTH      (TMO_W),
        .LOAD_VALUE (TMO_LOAD)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_get),
        .load    (tmo_load),
        .dec     (in_get && !rx_present),
        .expired (tmo_expired)
    );

    assign rx_read     = pop;
    assign tx_data     = resp;
    assign tx_write    = (state == ST_SEND) && !tx_full;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_wr_en   = (state == ST_BUS_WR);
    assign reg_rd_en   = (state == ST_BUS_RD);
    assign err_count   = err_q;
    assign busy        = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_hub.sv
// ============================================================================
//  Module      : tb_uart_cmd_hub
//  Description : Scoreboard bench for uart_cmd_hub: directed frames feed a
//                receive-FIFO model; a monitor checks bus strobes and
//                transmitted bytes against queued expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_hub;

    localparam int TMO = 60;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_present = 1'b0;
    logic       rx_read;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_full = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'h00;
    logic [7:0] err_count;
    logic       busy;

    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];
    logic [7:0] mem [256];

    int  checks = 0;
    int  fails = 0;
    int  cyc = 0;
    int  last_pop_cyc = -10;
    int  tx_count = 0;
    bit  prev_pop = 1'b0;
    bit  pop_now = 1'b0;

    uart_cmd_hub #(
        .TIMEOUT_CYCLES (TMO),
        .ACK_CHAR       (8'h4B),
        .NAK_CHAR       (8'h3F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_present  (rx_present),
        .rx_read     (rx_read),
        .tx_data     (tx_data),
        .tx_write    (tx_write),
        .tx_full     (tx_full),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receive FIFO model: head byte changes just after the clock edge of a pop
    always @(posedge clk) begin
        pop_now = rx_read;
        #1;
        if (pop_now && (rxq.size() != 0)) void'(rxq.pop_front());
        rx_present = (rxq.size() != 0);
        rx_data    = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    // Register file model: read data valid the cycle after reg_rd_en
    always @(posedge clk) begin
        if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
        if (reg_rd_en) reg_rd_data <= mem[reg_addr];
    end

    // Monitor: compare every strobe and transmitted byte with the scoreboard
    always @(negedge clk) begin
        bus_t       e;
        logic [7:0] t;
        if (reset) begin
            prev_pop = 1'b0;
        end else begin
            if (rx_read) begin
                checks++;
                if (prev_pop) begin
                    fails++;
                    $display("FAIL pop_spacing: rx_read high on consecutive cycles at cycle %0d, required an idle gap", cyc);
                end
                last_pop_cyc = cyc;
            end
            prev_pop = rx_read;
            if (reg_wr_en || reg_rd_en) begin
                checks++;
                if (exp_bus.size() == 0) begin
                    fails++;
                    $display("FAIL bus_unexpected: wr_en=%0b rd_en=%0b addr=%h, required no strobe", reg_wr_en, reg_rd_en, reg_addr);
                end else begin
                    e = exp_bus.pop_front();
                    if (reg_wr_en !== e.wr || reg_rd_en !== !e.wr || reg_addr !== e.addr ||
                        (e.wr && reg_wr_data !== e.data) || cyc != last_pop_cyc + 1) begin
                        fails++;
                        $display("FAIL bus_txn: got wr=%0b rd=%0b addr=%h data=%h lat=%0d, required wr=%0b addr=%h data=%h lat=1",
                                 reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, cyc - last_pop_cyc, e.wr, e.addr, e.data);
                    end
                end
            end
            if (tx_write) begin
                tx_count++;
                checks++;
                if (exp_tx.size() == 0) begin
                    fails++;
                    $display("FAIL tx_unexpected: got tx_data=%h, required no response", tx_data);
                end else begin
                    t = exp_tx.pop_front();
                    if (tx_data !== t) begin
                        fails++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, t);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the scoreboard to drain and the FSM to return to IDLE
    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || rxq.size() != 0 ||
                rx_present || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            fails++;
            $display("FAIL %s_timeout: pending tx=%0d bus=%0d busy=%0b after %0d cycles, required drained",
                     name, exp_tx.size(), exp_bus.size(), busy, limit);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rx_read"},  {7'd0, rx_read},   8'h00);
        check({name, "_tx_write"}, {7'd0, tx_write},  8'h00);
        check({name, "_tx_data"},  tx_data,           8'h00);
        check({name, "_addr"},     reg_addr,          8'h00);
        check({name, "_wr_data"},  reg_wr_data,       8'h00);
        check({name, "_strobes"},  {6'd0, reg_wr_en, reg_rd_en}, 8'h00);
        check({name, "_err"},      err_count,         8'h00);
        check({name, "_busy"},     {7'd0, busy},      8'h00);
    endtask

    initial begin
        int tx_before;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        wait_cycles(3);
        check_all_zero("reset");
        reset = 1'b0;
        wait_cycles(3);

        // Write frame W 05 A5 -> ACK
        exp_bus.push_back('{wr: 1'b1, addr: 8'h05, data: 8'hA5});
        exp_tx.push_back(8'h4B);
        rxq.push_back(8'h57); rxq.push_back(8'h05); rxq.push_back(8'hA5);
        wait_done("write", 100);

        // Read frame R 05 -> read byte A5
        exp_bus.push_back('{wr: 1'b0, addr: 8'h05, data: 8'h00});
        exp_tx.push_back(8'hA5);
        rxq.push_back(8'h52); rxq.push_back(8'h05);
        wait_done("read", 100);

        // Unknown opcode -> NAK and one error
        exp_tx.push_back(8'h3F);
        rxq.push_back(8'h11);
        wait_done("nak", 100);
        check("nak_err_count", err_count, 8'h01);

        // Status -> {err[3:0], 000, tx_full}
        exp_tx.push_back(8'h10);
        rxq.push_back(8'h53);
        wait_done("status", 100);

        // Partial write then silence -> timeout, no strobe, no response
        tx_before = tx_count;
        rxq.push_back(8'h57); rxq.push_back(8'h05);
        wait_cycles(TMO + 20);
        check("tmo_err_count", err_count, 8'h02);
        check("tmo_busy", {7'd0, busy}, 8'h00);
        check("tmo_no_tx", 8'(tx_count - tx_before), 8'h00);

        // Read after timeout still serviced
        exp_bus.push_back('{wr: 1'b0, addr: 8'h05, data: 8'h00});
        exp_tx.push_back(8'hA5);
        rxq.push_back(8'h52); rxq.push_back(8'h05);
        wait_done("read2", 100);

        // Transmit FIFO full held across SEND for 500 cycles
        tx_full = 1'b1;
        tx_before = tx_count;
        exp_bus.push_back('{wr: 1'b1, addr: 8'h07, data: 8'h3C});
        exp_tx.push_back(8'h4B);
        rxq.push_back(8'h57); rxq.push_back(8'h07); rxq.push_back(8'h3C);
        wait_cycles(500);
        check("full_no_tx", 8'(tx_count - tx_before), 8'h00);
        check("full_busy", {7'd0, busy}, 8'h01);
        check("full_err_count", err_count, 8'h02);
        tx_full = 1'b0;
        wait_done("full_release", 50);
        wait_cycles(5);
        check("full_one_tx", 8'(tx_count - tx_before), 8'h01);

        // Reset in GET_DATA drops the partial frame
        rxq.push_back(8'h57); rxq.push_back(8'h09);
        wait_cycles(12);
        check("mid_busy", {7'd0, busy}, 8'h01);
        check("mid_addr", reg_addr, 8'h09);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(20);
        check("post_reset_busy", {7'd0, busy}, 8'h00);

        // A fresh write completes normally
        exp_bus.push_back('{wr: 1'b1, addr: 8'h0A, data: 8'h5A});
        exp_tx.push_back(8'h4B);
        rxq.push_back(8'h57); rxq.push_back(8'h0A); rxq.push_back(8'h5A);
        wait_done("write_after_reset", 100);
        wait_cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
